// File: rtl/pushbutton_conditioner.sv
// -----------------------------------------------------------------------------
// pushbutton_conditioner
//
// Conditions four asynchronous, bouncing pushbutton levels into a clean button
// word for the processor. Each bit is synchronized through two flops and then
// debounced by its own counter. A level is accepted only after
// DEBOUNCE_CYCLES consecutive synchronized samples disagree with the current
// debounced level. Every accepted press (debounced 0->1) raises a one-cycle
// pulse on that bit.
//
// Optional feature, selected at compile time by the macro BTN_PRESS_LATCH_EN:
//   defined   : a sticky 4-bit latch records every press pulse until the
//               processor acknowledges with in_ack (a press on the same edge
//               as in_ack wins). pushbuttons = latch, press_pending = |latch.
//   undefined : no latch is built. pushbuttons = debounced levels,
//               press_pending = |debounced levels, in_ack is ignored.
//
// Parameters
//   DEBOUNCE_CYCLES  consecutive mismatched samples needed to accept a new
//                    level, legal range 1..15 (default 4)
//
// Ports
//   clock          system clock, all state changes on its rising edge
//   reset          synchronous, active-high reset
//   buttons_raw    raw pushbutton levels, asynchronous, 1 = pressed
//   in_ack         one-cycle strobe from the processor input read
//   pushbuttons    conditioned button word for the processor
//   press_pulse    one-cycle pulse per bit on each accepted press
//   press_pending  at least one press is available to the processor
//
// Latency: a raw level that is stable before edge E appears on the debounced
// level at edge E+DEBOUNCE_CYCLES+1. Two of those edges are spent in the
// synchronizer, and DEBOUNCE_CYCLES are spent counting.
// -----------------------------------------------------------------------------
module pushbutton_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] buttons_raw,
  input  logic       in_ack,
  output logic [3:0] pushbuttons,
  output logic [3:0] press_pulse,
  output logic       press_pending
);

  localparam int unsigned NUM_BUTTONS = 4;

  // Counter value held when the final mismatched sample arrives. The counter
  // never reaches DEBOUNCE_CYCLES, so it cannot wrap.
  localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

  // IDLE: the synchronized level matches the debounced level, and the counter
  // rests at zero. COUNTING: a run of mismatched samples is being timed.
  typedef enum logic {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } deb_state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [3:0] sync1;
  logic [3:0] sync2;
  logic [3:0] deb_q;
  logic [3:0] deb_d;
  logic [3:0] pulse_q;

  logic [3:0] cnt_q   [NUM_BUTTONS];
  logic [3:0] cnt_d   [NUM_BUTTONS];
  deb_state_t state_q [NUM_BUTTONS];
  deb_state_t state_d [NUM_BUTTONS];

  // ---------------------------------------------------------------------------
  // Per-bit debounce next-state logic. The bits share no signals, so
  // simultaneous changes on several buttons are handled fully in parallel.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      // NOTE: every output of this block gets a default before the case, so
      //       no path leaves a signal unassigned and no latch is inferred.
      deb_d[i]   = deb_q[i];
      cnt_d[i]   = cnt_q[i];
      state_d[i] = state_q[i];

      case (state_q[i])
        IDLE: begin
          cnt_d[i] = '0;
          if (sync2[i] != deb_q[i]) begin
            if (CNT_LAST == 4'd0) begin
              // A single-sample debounce accepts at once and keeps no count,
              // so the debounced level trails sync2 by one cycle.
              deb_d[i] = sync2[i];
            end else begin
              cnt_d[i]   = 4'd1;
              state_d[i] = COUNTING;
            end
          end
        end

        COUNTING: begin
          if (sync2[i] == deb_q[i]) begin
            // Bounce back to the old level: discard the partial count.
            cnt_d[i]   = '0;
            state_d[i] = IDLE;
          end else if (cnt_q[i] == CNT_LAST) begin
            // This is the DEBOUNCE_CYCLES-th consecutive mismatch: accept it.
            deb_d[i]   = sync2[i];
            cnt_d[i]   = '0;
            state_d[i] = IDLE;
          end else begin
            cnt_d[i] = cnt_q[i] + 4'd1;
          end
        end

        default: begin
          cnt_d[i]   = '0;
          state_d[i] = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers: synchronizer, debounce state and the press pulse
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments. Every flop then
    //       samples pre-edge values, and the sync1 -> sync2 chain stays two
    //       stages deep instead of collapsing into one.
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      deb_q   <= '0;
      pulse_q <= '0;
      // NOTE: the per-bit counter arrays are small register files and must be
      //       cleared explicitly. Otherwise a count that was in progress when
      //       reset arrived would carry on afterwards.
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        cnt_q[i]   <= '0;
        state_q[i] <= IDLE;
      end
    end else begin
      sync1   <= buttons_raw;
      sync2   <= sync1;
      deb_q   <= deb_d;
      // A pulse marks a rising debounced level only. A falling level is silent.
      pulse_q <= deb_d & ~deb_q;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        cnt_q[i]   <= cnt_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign press_pulse = pulse_q;

  // ---------------------------------------------------------------------------
  // Processor-facing word
  // ---------------------------------------------------------------------------
`ifdef BTN_PRESS_LATCH_EN
  logic [3:0] latch_q;

  // The acknowledge clears all bits first, and new presses are ORed in
  // afterwards. A press on the same edge as in_ack therefore survives.
  always_ff @(posedge clock) begin
    if (reset) begin
      latch_q <= '0;
    end else begin
      latch_q <= (in_ack ? 4'b0000 : latch_q) | pulse_q;
    end
  end

  assign pushbuttons   = latch_q;
  assign press_pending = |latch_q;
`else
  // With no latch, in_ack drives nothing. It is tied off here so the port
  // still exists for drop-in compatibility.
  logic in_ack_unused;
  assign in_ack_unused = in_ack;

  assign pushbuttons   = deb_q;
  assign press_pending = |deb_q;
`endif

endmodule
